comparator_serial: RTL and testbench

COMPARATOR_SERIAL -- requirements
Module: comparator_serial

---
 rtl/comparator_pkg.sv | 28 ++
 rtl/comparator_chunk.sv | 20 ++
 rtl/comparator_serial.sv | 143 ++++++++++++++
 tb/tb_comparator_serial.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
// Shared types for the serial comparator: FSM state encoding, the one-hot
// result encoding {lt, gt, eq}, and a helper that sizes the slice counter.
// No ports.
// -----------------------------------------------------------------------------
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result vector ordering matches the output pins {a_lt_b, a_gt_b, a_eq_b}.
  typedef logic [2:0] res_t;

  localparam res_t LT       = 3'b100;
  localparam res_t GT       = 3'b010;
  localparam res_t EQ       = 3'b001;
  localparam res_t RES_NONE = 3'b000;

  // Counter width for N slices; a single-slice build still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// -----------------------------------------------------------------------------
// comparator_chunk
// Purely combinational unsigned compare of one CHUNK-bit slice.
//   i_a, i_b : slice operands
//   o_lt     : i_a <  i_b
//   o_gt     : i_a >  i_b
// -----------------------------------------------------------------------------
module comparator_chunk #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_lt,
  output logic             o_gt
);

  assign o_lt = (i_a < i_b);
  assign o_gt = (i_a > i_b);

endmodule

// File: rtl/comparator_serial.sv
// -----------------------------------------------------------------------------
// comparator_serial
// Multi-cycle magnitude comparator. Operands are captured on start in IDLE and
// compared CHUNK bits per cycle, most-significant slice first. The first slice
// that differs fixes the verdict; the result is registered on entry to DONE.
//
// Parameters
//   WIDTH : operand width (>= 2)
//   CHUNK : bits compared per cycle (must divide WIDTH); N = WIDTH/CHUNK
//
// Ports
//   clk                    : clock, rising edge
//   rst_n                  : asynchronous active-low reset
//   start                  : request, sampled only in IDLE
//   a, b                   : operands, sampled with start
//   is_signed              : 1 = two's-complement, 0 = unsigned, sampled with start
//   busy                   : high while in RUN
//   done                   : one-cycle completion pulse (DONE state)
//   a_lt_b, a_gt_b, a_eq_b : registered one-hot result, held until next DONE
//
// Build option
//   COMPARATOR_EARLY_EXIT_EN : leave RUN right after the first differing slice
//                              instead of always scanning all N slices.
// -----------------------------------------------------------------------------
module comparator_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b
);

  localparam int N     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CNT_W = cnt_width(N);

  if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
    $error("comparator_serial: illegal WIDTH=%0d / CHUNK=%0d", WIDTH, CHUNK);
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  res_t             r_verdict;
  res_t             w_verdict_nxt;
  res_t             r_res;
  logic [N-1:0]     w_lt;
  logic [N-1:0]     w_gt;
  logic             w_sel_lt;
  logic             w_sel_gt;
  logic             w_last;
  logic [WIDTH-1:0] w_sign_mask;

  // Flipping both MSBs maps two's-complement order onto unsigned order, so
  // every slice can then be compared unsigned.
  assign w_sign_mask = {is_signed, {(WIDTH-1){1'b0}}};

  // Slice 0 is the most-significant slice, matching the counter order.
  for (genvar i = 0; i < N; i++) begin : g_slice
    comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
      .i_a  (r_a[WIDTH-1-i*CHUNK -: CHUNK]),
      .i_b  (r_b[WIDTH-1-i*CHUNK -: CHUNK]),
      .o_lt (w_lt[i]),
      .o_gt (w_gt[i])
    );
  end

  assign w_sel_lt = w_lt[r_cnt];
  assign w_sel_gt = w_gt[r_cnt];

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_verdict_nxt = r_verdict;
    w_last        = (r_cnt == CNT_W'(N - 1));
`ifdef COMPARATOR_EARLY_EXIT_EN
    // Any difference at this point is the first one, because an earlier one
    // would already have ended the scan.
    w_last        = w_last | w_sel_lt | w_sel_gt;
`endif
    unique case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN: begin
        // Only the first differing slice may set the verdict.
        if (r_verdict == EQ) begin
          if (w_sel_lt)      w_verdict_nxt = LT;
          else if (w_sel_gt) w_verdict_nxt = GT;
        end
        if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the operand registers are ordinary flops and are cleared on reset;
  // this keeps post-reset state fully defined for a trivial cost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_verdict <= EQ;
      r_res     <= RES_NONE;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_a       <= a ^ w_sign_mask;
        r_b       <= b ^ w_sign_mask;
        r_cnt     <= '0;
        r_verdict <= EQ;
      end else if (r_state == RUN) begin
        r_cnt     <= r_cnt + 1'b1;
        r_verdict <= w_verdict_nxt;
        if (w_last) r_res <= w_verdict_nxt;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign {a_lt_b, a_gt_b, a_eq_b} = r_res;

endmodule

// File: tb/tb_comparator_serial.sv
// -----------------------------------------------------------------------------
// tb_comparator_serial
// Directed bench for comparator_serial. Two instances share clock and reset:
// u_dut1 (WIDTH=8, CHUNK=1) and u_dut4 (WIDTH=8, CHUNK=4). Latency is counted
// in rising edges from the start-sampling edge k to the edge after which done
// is seen; done in cycle k+L+1 corresponds to L edges.
// Honours COMPARATOR_EARLY_EXIT_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_comparator_serial;

`ifdef COMPARATOR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       s1_start = 1'b0, s1_signed = 1'b0;
  logic [7:0] s1_a = '0, s1_b = '0;
  logic       s1_busy, s1_done, s1_lt, s1_gt, s1_eq;

  logic       s4_start = 1'b0, s4_signed = 1'b0;
  logic [7:0] s4_a = '0, s4_b = '0;
  logic       s4_busy, s4_done, s4_lt, s4_gt, s4_eq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  comparator_serial #(.WIDTH(8), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b),
    .is_signed(s1_signed), .busy(s1_busy), .done(s1_done),
    .a_lt_b(s1_lt), .a_gt_b(s1_gt), .a_eq_b(s1_eq)
  );

  comparator_serial #(.WIDTH(8), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .a(s4_a), .b(s4_b),
    .is_signed(s4_signed), .busy(s4_busy), .done(s4_done),
    .a_lt_b(s4_lt), .a_gt_b(s4_gt), .a_eq_b(s4_eq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {lt, gt, eq}.
  function automatic logic [2:0] ref_cmp(input logic [7:0] va, vb, input logic vs);
    logic lt, gt;
    if (vs) begin
      lt = $signed(va) < $signed(vb);
      gt = $signed(va) > $signed(vb);
    end else begin
      lt = va < vb;
      gt = va > vb;
    end
    return {lt, gt, !(lt || gt)};
  endfunction

  // Expected edges from k to the DONE-entry edge.
  function automatic int exp_lat(input logic [7:0] va, vb, input logic vs, input int chunk);
    int n = 8 / chunk;
    int msk = (1 << chunk) - 1;
    int aa = int'(va) ^ (vs ? 128 : 0);
    int bb = int'(vb) ^ (vs ? 128 : 0);
    if (!EARLY) return n;
    for (int j = 0; j < n; j++) begin
      int sh = 8 - (j + 1) * chunk;
      if (((aa >> sh) & msk) != ((bb >> sh) & msk)) return j + 1;
    end
    return n;
  endfunction

  // One operation on the selected instance; returns with the DUT back in IDLE.
  task automatic run_op(input bit sel, input logic [7:0] va, vb, input logic vs,
                        output logic [2:0] res, output int lat);
    logic d;
    @(negedge clk);
    if (sel) begin s4_a = va; s4_b = vb; s4_signed = vs; s4_start = 1'b1; end
    else     begin s1_a = va; s1_b = vb; s1_signed = vs; s1_start = 1'b1; end
    @(posedge clk); #1;
    s1_start = 1'b0; s4_start = 1'b0;
    // Operands are don't-care once sampled.
    s1_a = ~va; s1_b = va; s1_signed = ~vs;
    s4_a = ~va; s4_b = va; s4_signed = ~vs;
    check("busy_in_run", sel ? s4_busy : s1_busy, 1);
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      d = sel ? s4_done : s1_done;
      if (d) break;
      if (lat > 20) begin
        check("done_timeout", 0, 1);
        break;
      end
    end
    res = sel ? {s4_lt, s4_gt, s4_eq} : {s1_lt, s1_gt, s1_eq};
    @(posedge clk); #1;
    check("done_one_cycle", sel ? s4_done : s1_done, 0);
    check("result_held", sel ? {s4_lt, s4_gt, s4_eq} : {s1_lt, s1_gt, s1_eq}, res);
  endtask

  typedef struct {
    string      tag;
    logic [7:0] va;
    logic [7:0] vb;
    logic       vs;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[8] = '{
    '{"eq_05_05_u", 8'h05, 8'h05, 1'b0, 3'b001},
    '{"s_80_7f",    8'h80, 8'h7F, 1'b1, 3'b100},
    '{"u_80_7f",    8'h80, 8'h7F, 1'b0, 3'b010},
    '{"u_80_00",    8'h80, 8'h00, 1'b0, 3'b010},
    '{"s_ff_00",    8'hFF, 8'h00, 1'b1, 3'b100},
    '{"u_01_02",    8'h01, 8'h02, 1'b0, 3'b100},
    '{"s_7f_80",    8'h7F, 8'h80, 1'b1, 3'b010},
    '{"s_fe_ff",    8'hFE, 8'hFF, 1'b1, 3'b100}
  };

  logic [7:0] a_list[11] = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h7E, 8'h7F,
                             8'h80, 8'h81, 8'hF0, 8'hFE, 8'hFF};

  initial begin
    logic [2:0] res;
    int         lat;
    int         n_done;

    // Reset state.
    #12;
    check("rst_busy", s1_busy, 0);
    check("rst_done", s1_done, 0);
    check("rst_res", {s1_lt, s1_gt, s1_eq}, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_res", {s1_lt, s1_gt, s1_eq}, 3'b000);

    // Directed vectors, CHUNK=1 (latency 8 edges, or earlier with early exit).
    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].va, vecs[i].vb, vecs[i].vs, res, lat);
      check({vecs[i].tag, "_res"}, res, vecs[i].exp);
      check({vecs[i].tag, "_lat"}, lat, exp_lat(vecs[i].va, vecs[i].vb, vecs[i].vs, 1));
    end

    // Reset mid-RUN: last result is nonzero, so clearing is observable.
    @(negedge clk);
    s1_a = 8'h80; s1_b = 8'h7F; s1_signed = 1'b1; s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", s1_busy, 0);
    check("abort_done", s1_done, 0);
    check("abort_res", {s1_lt, s1_gt, s1_eq}, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (s1_done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_res_hold", {s1_lt, s1_gt, s1_eq}, 3'b000);
    run_op(1'b0, 8'h10, 8'h20, 1'b0, res, lat);
    check("after_abort_res", res, 3'b100);
    check("after_abort_lat", lat, exp_lat(8'h10, 8'h20, 1'b0, 1));

    // Start held high with operands changing every cycle.
    begin
      int next_start = 0;
      int exp_done   = -1;
      logic [2:0] exp_res = 3'b000;
      for (int c = 0; c < 46; c++) begin
        logic [7:0] pa, pb;
        logic       ps;
        pa = 8'(c * 53 + 7);
        pb = 8'(c * 29 + 200);
        ps = (c % 3) == 0;
        @(negedge clk);
        s1_start = 1'b1; s1_a = pa; s1_b = pb; s1_signed = ps;
        @(posedge clk);
        if (c == next_start) begin
          exp_res    = ref_cmp(pa, pb, ps);
          exp_done   = c + exp_lat(pa, pb, ps, 1);
          next_start = exp_done + 2;
        end
        #1;
        if (s1_done || c == exp_done) begin
          check("hold_done_edge", s1_done ? c : -1, exp_done);
          check("hold_res", {s1_lt, s1_gt, s1_eq}, exp_res);
        end
      end
      @(negedge clk);
      s1_start = 1'b0;
      repeat (12) @(posedge clk);
    end

    // CHUNK=4 sweep: selected a values against every b, both modes.
    for (int s = 0; s < 2; s++) begin
      foreach (a_list[i]) begin
        for (int bv = 0; bv < 256; bv++) begin
          run_op(1'b1, a_list[i], 8'(bv), s[0], res, lat);
          check("c4_res", res, ref_cmp(a_list[i], 8'(bv), s[0]));
          check("c4_lat", lat, exp_lat(a_list[i], 8'(bv), s[0], 4));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
